// File: rtl/rv32_mem_pkg.sv
// Shared constants for the rv32i load/store path: funct3 access codes,
// LSU FSM state encoding and the access alignment rule.
package rv32_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  // Any funct3 with bit 1 set (010/011/110/111) is a word access.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    logic mis;
    if (f3[1:0] == F3_H[1:0]) begin
      mis = addr_lo[0];
    end else if (f3[1] == F3_W[1]) begin
      mis = (addr_lo != 2'b00);
    end else begin
      mis = 1'b0;
    end
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store data replication and byte strobes,
// plus load byte/halfword extraction with sign or zero extension.
module lsu_align
  import rv32_mem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign byte_s = rdata_i[{addr_lo_i, 3'b000} +: 8];
  assign half_s = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  // Size/signedness decode for both store placement and load extension.
  always_comb begin
    wdata_o = wdata_i;
    wstrb_o = 4'b1111;
    rdata_o = rdata_i;
    case (funct3_i)
      F3_B, F3_BU: begin
        wdata_o = {4{wdata_i[7:0]}};
        wstrb_o = 4'b0001 << addr_lo_i;
        rdata_o = (funct3_i == F3_BU) ? {24'h000000, byte_s} : {{24{byte_s[7]}}, byte_s};
      end
      F3_H, F3_HU: begin
        wdata_o = {2{wdata_i[15:0]}};
        wstrb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        rdata_o = (funct3_i == F3_HU) ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
      end
      default: begin
        wdata_o = wdata_i;
        wstrb_o = 4'b1111;
        rdata_o = rdata_i;
      end
    endcase
  end

endmodule

// File: rtl/lsu_dmem.sv
// Load/store unit bridging the rv32i datapath to a valid/ready data memory;
// stalls the core for the duration of each access.
module lsu_dmem
  import rv32_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        stall,
  output logic        misaligned,
  output logic        bus_err,
  output logic        mem_valid,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      read_data_q, read_data_d;
  logic             mem_valid_q, mem_valid_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic [3:0]       mem_wstrb_q, mem_wstrb_d;
  logic             mis_q, mis_d;
  logic             berr_q, berr_d;
  logic [2:0]       fmt_f3_q, fmt_f3_d;
  logic [1:0]       fmt_off_q, fmt_off_d;

  logic             req_s;
  logic             mis_s;
  logic [31:0]      req_wdata_s;
  logic [3:0]       req_wstrb_s;
  logic [31:0]      rsp_rdata_s;
  logic [31:0]      unused_req_rdata_s;
  logic [31:0]      unused_rsp_wdata_s;
  logic [3:0]       unused_rsp_wstrb_s;

  assign req_s = MemRead | MemWrite;
  assign mis_s = is_misaligned(funct3, ALUResult[1:0]);

  lsu_align u_req_align (
    .funct3_i  (funct3),
    .addr_lo_i (ALUResult[1:0]),
    .wdata_i   (WriteData),
    .rdata_i   (32'h00000000),
    .wdata_o   (req_wdata_s),
    .wstrb_o   (req_wstrb_s),
    .rdata_o   (unused_req_rdata_s)
  );

  lsu_align u_rsp_align (
    .funct3_i  (fmt_f3_q),
    .addr_lo_i (fmt_off_q),
    .wdata_i   (32'h00000000),
    .rdata_i   (mem_rdata),
    .wdata_o   (unused_rsp_wdata_s),
    .wstrb_o   (unused_rsp_wstrb_s),
    .rdata_o   (rsp_rdata_s)
  );

  // Stall is raised in the accepting IDLE cycle already; reset forces it low at once.
  assign stall = rst & ((state_q == ST_BUSY) |
                        ((state_q == ST_IDLE) & req_s & ~mis_s));

  // Access sequencing, timeout and response capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    read_data_d = read_data_q;
    mem_valid_d = mem_valid_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    fmt_f3_d    = fmt_f3_q;
    fmt_off_d   = fmt_off_q;
    mis_d       = 1'b0;
    berr_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_s && mis_s) begin
          mis_d       = 1'b1;
          read_data_d = 32'h00000000;
        end else if (req_s) begin
          mem_we_d    = MemWrite;
          mem_addr_d  = {ALUResult[31:2], 2'b00};
          mem_wdata_d = MemWrite ? req_wdata_s : 32'h00000000;
          mem_wstrb_d = MemWrite ? req_wstrb_s : 4'b0000;
          fmt_f3_d    = funct3;
          fmt_off_d   = ALUResult[1:0];
          mem_valid_d = 1'b1;
          cnt_d       = {CNT_W{1'b0}};
          state_d     = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (mem_ready) begin
          mem_valid_d = 1'b0;
          state_d     = ST_DONE;
          read_data_d = mem_we_q ? read_data_q : rsp_rdata_s;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          mem_valid_d = 1'b0;
          read_data_d = 32'h00000000;
          berr_d      = 1'b1;
          state_d     = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        mem_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      read_data_q <= 32'h00000000;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h00000000;
      mem_wdata_q <= 32'h00000000;
      mem_wstrb_q <= 4'b0000;
      mis_q       <= 1'b0;
      berr_q      <= 1'b0;
      fmt_f3_q    <= 3'b000;
      fmt_off_q   <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      read_data_q <= read_data_d;
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      mis_q       <= mis_d;
      berr_q      <= berr_d;
      fmt_f3_q    <= fmt_f3_d;
      fmt_off_q   <= fmt_off_d;
    end
  end

  assign ReadData   = read_data_q;
  assign misaligned = mis_q;
  assign bus_err    = berr_q;
  assign mem_valid  = mem_valid_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wstrb  = mem_wstrb_q;

endmodule

// File: tb/tb_lsu_dmem.sv
// Self-checking bench for lsu_dmem: directed loads/stores, alignment,
// timeout and asynchronous reset, plus randomized accesses vs a reference model.
module tb_lsu_dmem;

  logic        clk;
  logic        rst;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  funct3;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        stall;
  logic        misaligned;
  logic        bus_err;
  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int checks = 0;
  int fails  = 0;
  logic [31:0] ref_rd = 32'h0;

  lsu_dmem #(.TIMEOUT(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
    .funct3(funct3), .ALUResult(ALUResult), .WriteData(WriteData),
    .ReadData(ReadData), .stall(stall), .misaligned(misaligned),
    .bus_err(bus_err), .mem_valid(mem_valid), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (byte-count arithmetic) ----------------
  function automatic int unsigned sz_of(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic int unsigned off_of(input logic [2:0] f3, input logic [31:0] addr);
    int unsigned n = sz_of(f3);
    return ((addr % 4) / n) * n;
  endfunction

  function automatic logic ref_mis(input logic [2:0] f3, input logic [31:0] addr);
    return (addr % sz_of(f3)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] word);
    int unsigned n = sz_of(f3);
    longint unsigned lim, v;
    if (n == 4) return word;
    lim = 64'd1 << (8 * n);
    v = (64'(word) >> (8 * off_of(f3, addr))) % lim;
    if (!f3[2] && v >= lim / 2) v = v + 64'h1_0000_0000 - lim;
    return v[31:0];
  endfunction

  function automatic logic [3:0] ref_strb(input logic [2:0] f3, input logic [31:0] addr);
    int unsigned n = sz_of(f3);
    int unsigned m = ((1 << n) - 1) << off_of(f3, addr);
    return m[3:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    int unsigned n = sz_of(f3);
    if (n == 1) return (rs2 % 256) * 32'h01010101;
    if (n == 2) return (rs2 % 65536) * 32'h00010001;
    return rs2;
  endfunction

  // ---------------- one aligned access with a memory that answers after 'waits' ----------------
  task automatic do_access(input logic st, input logic both, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] rs2,
                           input logic [31:0] rdw, input int waits);
    int stalls = 0;
    logic [3:0]  estrb;
    logic [31:0] ewd;
    estrb = st ? ref_strb(f3, addr) : 4'b0000;
    ewd   = ref_wdata(f3, rs2);
    @(posedge clk); #1;
    MemRead = ~st | both; MemWrite = st; funct3 = f3; ALUResult = addr; WriteData = rs2;
    mem_ready = 1'b0;
    @(negedge clk);
    if (stall) stalls++;
    checks++;
    if (mem_valid !== 1'b0) begin fails++; $display("FAIL idle_valid: got %b want 0", mem_valid); end
    for (int i = 0; i <= waits; i++) begin
      @(posedge clk); #1;
      mem_ready = (i == waits);
      mem_rdata = (i == waits) ? rdw : $urandom;
      @(negedge clk);
      if (stall) stalls++;
      checks++;
      if ({mem_valid, mem_we, mem_addr, mem_wstrb} !== {1'b1, st, addr[31:2], 2'b00, estrb}) begin
        fails++;
        $display("FAIL busy_req: got v=%b we=%b addr=%h strb=%b want v=1 we=%b addr=%h strb=%b",
                 mem_valid, mem_we, mem_addr, mem_wstrb, st, {addr[31:2], 2'b00}, estrb);
      end
      if (st) begin
        checks++;
        if (mem_wdata !== ewd) begin fails++; $display("FAIL busy_wdata: got %h want %h", mem_wdata, ewd); end
      end
    end
    @(posedge clk); #1;
    mem_ready = 1'b0;
    if (!st) ref_rd = ref_load(f3, addr, rdw);
    @(negedge clk);
    if (stall) stalls++;
    checks++;
    if ({mem_valid, bus_err, misaligned} !== 3'b000) begin
      fails++; $display("FAIL done_flags: got v/berr/mis=%b want 000", {mem_valid, bus_err, misaligned});
    end
    checks++;
    if (ReadData !== ref_rd) begin
      fails++; $display("FAIL readdata f3=%b addr=%h: got %h want %h", f3, addr, ReadData, ref_rd);
    end
    checks++;
    if (stalls != waits + 2) begin fails++; $display("FAIL stall_cycles: got %0d want %0d", stalls, waits + 2); end
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  // ---------------- one misaligned request, held for a single cycle ----------------
  task automatic do_mis(input logic st, input logic [2:0] f3, input logic [31:0] addr);
    @(posedge clk); #1;
    MemRead = ~st; MemWrite = st; funct3 = f3; ALUResult = addr; WriteData = $urandom;
    @(negedge clk);
    checks++;
    if ({stall, mem_valid} !== 2'b00) begin fails++; $display("FAIL mis_req: got stall/valid=%b want 00", {stall, mem_valid}); end
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0;
    ref_rd = 32'h0;
    @(negedge clk);
    checks++;
    if ({misaligned, mem_valid, stall, ReadData} !== {3'b100, 32'h0}) begin
      fails++; $display("FAIL mis_pulse: got mis=%b v=%b stall=%b rd=%h want 1 0 0 0", misaligned, mem_valid, stall, ReadData);
    end
    @(negedge clk);
    checks++;
    if (misaligned !== 1'b0) begin fails++; $display("FAIL mis_width: got %b want 0", misaligned); end
  endtask

  task automatic test_reset;
    checks++;
    if ({ReadData, mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb, misaligned, bus_err, stall} !== 104'h0) begin
      fails++;
      $display("FAIL reset_state: rd=%h v=%b we=%b a=%h wd=%h s=%b mis=%b be=%b st=%b want all 0",
               ReadData, mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb, misaligned, bus_err, stall);
    end
  endtask

  task automatic test_loads;
    do_access(1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    checks++;
    if (ReadData !== 32'hDEADBEEF) begin fails++; $display("FAIL lw: got %h want deadbeef", ReadData); end
    do_access(1'b0, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80123456, 1);
    checks++;
    if (ReadData !== 32'hFFFFFF80) begin fails++; $display("FAIL lb: got %h want ffffff80", ReadData); end
    do_access(1'b0, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80123456, 0);
    checks++;
    if (ReadData !== 32'h00000080) begin fails++; $display("FAIL lbu: got %h want 00000080", ReadData); end
    do_access(1'b0, 1'b0, 3'b001, 32'h102, 32'h0, 32'h80123456, 2);
    checks++;
    if (ReadData !== 32'hFFFF8012) begin fails++; $display("FAIL lh: got %h want ffff8012", ReadData); end
  endtask

  task automatic test_stores;
    do_access(1'b1, 1'b0, 3'b000, 32'h201, 32'h000000AB, 32'h55555555, 0);
    checks++;
    if ({mem_wdata, mem_wstrb, mem_we, mem_addr, ReadData} !== {32'hABABABAB, 4'b0010, 1'b1, 32'h200, 32'hFFFF8012}) begin
      fails++; $display("FAIL sb: wd=%h s=%b we=%b a=%h rd=%h", mem_wdata, mem_wstrb, mem_we, mem_addr, ReadData);
    end
    do_access(1'b1, 1'b1, 3'b001, 32'h202, 32'h00001234, 32'h55555555, 1);
    checks++;
    if ({mem_wdata, mem_wstrb, ReadData} !== {32'h12341234, 4'b1100, 32'hFFFF8012}) begin
      fails++; $display("FAIL sh: wd=%h s=%b rd=%h", mem_wdata, mem_wstrb, ReadData);
    end
  endtask

  task automatic test_misaligned;
    do_mis(1'b0, 3'b010, 32'h102);
    do_mis(1'b1, 3'b001, 32'h305);
  endtask

  task automatic test_timeout;
    int nv = 0;
    int nb = 0;
    logic [31:0] rs2;
    rs2 = $urandom;
    do_access(1'b0, 1'b0, 3'b010, 32'h40, 32'h0, 32'hCAFEF00D, 0);
    @(posedge clk); #1;
    MemWrite = 1'b1; MemRead = 1'b0; funct3 = 3'b010; ALUResult = 32'h400; WriteData = rs2; mem_ready = 1'b0;
    for (int i = 0; i < 10 && nb == 0; i++) begin
      @(negedge clk);
      if (mem_valid) begin
        nv++;
        checks++;
        if ({mem_we, mem_addr, mem_wdata, mem_wstrb, stall} !== {1'b1, 32'h400, rs2, 4'hF, 1'b1}) begin
          fails++; $display("FAIL to_stable: we=%b a=%h wd=%h s=%b st=%b", mem_we, mem_addr, mem_wdata, mem_wstrb, stall);
        end
      end
      if (bus_err) begin
        nb++;
        checks++;
        if ({stall, mem_valid, ReadData} !== {2'b00, 32'h0}) begin
          fails++; $display("FAIL to_done: st=%b v=%b rd=%h want 0 0 0", stall, mem_valid, ReadData);
        end
      end
    end
    ref_rd = 32'h0;
    @(posedge clk); #1;
    MemWrite = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus_err, stall} !== 2'b00) begin fails++; $display("FAIL to_pulse: berr/stall=%b want 00", {bus_err, stall}); end
    checks++;
    if (nv != 4 || nb != 1) begin fails++; $display("FAIL to_counts: valid=%0d berr=%0d want 4 1", nv, nb); end
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'b010; ALUResult = 32'h300; mem_ready = 1'b0;
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    checks++;
    if ({mem_valid, stall} !== 2'b00) begin fails++; $display("FAIL rst_mid: v/stall=%b want 00", {mem_valid, stall}); end
    @(negedge clk);
    @(posedge clk); #1;
    MemRead = 1'b0;
    rst = 1'b1;
    ref_rd = 32'h0;
    checks++;
    if (ReadData !== 32'h0) begin fails++; $display("FAIL rst_rd: got %h want 0", ReadData); end
    do_access(1'b0, 1'b0, 3'b010, 32'h500, 32'h0, 32'h13572468, 0);
  endtask

  task automatic test_random;
    for (int k = 0; k < 40; k++) begin
      logic st;
      logic [2:0] f3;
      logic [31:0] addr;
      st   = 1'($urandom_range(0, 1));
      f3   = st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      addr = $urandom;
      if (ref_mis(f3, addr)) do_mis(st, f3, addr);
      else do_access(st, 1'($urandom_range(0, 1)), f3, addr, $urandom, $urandom, $urandom_range(0, 3));
    end
  endtask

  initial begin
    rst = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'b000;
    ALUResult = 32'h0; WriteData = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    test_reset;
    test_loads;
    test_stores;
    test_misaligned;
    test_timeout;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/lsu_dmem.md
Name: lsu_dmem

Overview:
Load/store unit between the rv32i dataPath and a handshaked data memory.
- Consumes ALUResult (address), WriteData and funct3 from the datapath, and MemRead/MemWrite from the control unit.
- Returns ReadData for the ResultSrc mux, formatted for byte/halfword/word access with sign or zero extension.
- Asserts stall while an access is in flight, freezing the PC and register-file write.

Parameters:
TIMEOUT, 255, max BUSY cycles waiting for mem_ready before abort (1..65535)
CNT_W, 16, width of timeout counter; must hold TIMEOUT

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low
MemRead  in  1  load request, held for the whole instruction
MemWrite  in  1  store request, held for the whole instruction
funct3  in  3  instruction[14:12], access size and signedness
ALUResult  in  32  byte address
WriteData  in  32  store data (rs2)
ReadData  out  32  formatted load result
stall  out  1  hold PC and suppress RegWrite while 1
misaligned  out  1  one-cycle pulse: misaligned access rejected
bus_err  out  1  one-cycle pulse: timeout abort
mem_valid  out  1  request valid to memory
mem_we  out  1  1 = write
mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
mem_wdata  out  32  lane-positioned store data
mem_wstrb  out  4  byte-lane write enables
mem_ready  in  1  memory accepts or completes the request this cycle
mem_rdata  in  32  read word, valid when mem_ready=1 and mem_we=0

Behaviour:
- Reset (rst=0): immediate, not clock-gated. state=IDLE; ReadData=0, mem_valid=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, misaligned=0, bus_err=0, counter=0. Reset mid-access drops mem_valid at once and aborts the access; no response is kept.
- Request: req = MemRead|MemWrite. If both are 1, the access is a store.
- Alignment rule:
  - funct3[1:0]=01 (halfword): misaligned if addr[0]=1.
  - funct3[1:0]=10 (word): misaligned if addr[1:0]!=0.
  - Bytes are never misaligned.
  - funct3 011/110/111 are treated as word access.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, req=0: stall=0, nothing happens.
  - IDLE, req=1 and misaligned: no memory access, no state change. misaligned=1 next cycle for one cycle; ReadData <= 0.
  - IDLE, req=1 and aligned: stall=1 combinationally. Latch mem_we, mem_addr, mem_wdata, mem_wstrb and load format (size, unsigned bit, addr[1:0]). Set mem_valid<=1, counter<=0, go BUSY.
  - BUSY: stall=1; mem_valid and all mem_* outputs stay stable until mem_ready.
    - On mem_ready: mem_valid<=0, go DONE. For a load, ReadData <= formatted mem_rdata.
    - Otherwise counter++. If counter==TIMEOUT-1: mem_valid<=0, ReadData<=0, bus_err pulses next cycle, go DONE.
  - DONE: stall=0; the core commits, PC advances at the end of this cycle. req is ignored because it still belongs to the same instruction. Go IDLE.
- Latency: with mem_ready=1 on the first BUSY cycle, the access takes 3 cycles (IDLE, BUSY, DONE) and stall is high for 2 cycles. Each extra wait cycle adds 1.
- Store formatting:
  - SB: wdata = {4{rs2[7:0]}}, wstrb = 0001<<addr[1:0].
  - SH: wdata = {2{rs2[15:0]}}, wstrb = addr[1] ? 1100 : 0011.
  - SW: wdata = rs2, wstrb = 1111.
  - Loads drive wstrb=0000.
- Load formatting: select byte by addr[1:0] or halfword by addr[1].
  - LB/LH: sign-extend. LBU/LHU: zero-extend. LW: pass through.
- ReadData holds its last value except on load completion, misaligned access, or timeout. Stores never change ReadData.

Decomposition:
- Package rv32_mem_pkg holds:
  - funct3 constants: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - FSM state encoding: IDLE=00, BUSY=01, DONE=10.
  - Function for the alignment check.
- Sub-module lsu_align: purely combinational. Store lane placement and strobes, plus load extraction and extension. Instantiated twice: once on the request path and once on the response path with the latched format.

Test Plan:
- LW addr 0x100, mem_rdata=0xDEADBEEF, mem_ready on first BUSY cycle -> mem_addr=0x100, mem_wstrb=0000; stall high 2 cycles; ReadData=0xDEADBEEF in DONE.
- LB addr 0x103 and LBU addr 0x103, mem_rdata=0x80123456 -> ReadData 0xFFFFFF80 and 0x00000080 respectively. LH addr 0x102 -> 0xFFFF8012.
- SB addr 0x201 with rs2=0x000000AB -> mem_wdata=0xABABABAB, wstrb=0010, mem_we=1, mem_addr=0x200. SH addr 0x202 with rs2=0x1234 -> wstrb=1100. ReadData unchanged.
- LW addr 0x102 -> no mem_valid; misaligned=1 for exactly 1 cycle; stall never asserted; ReadData=0.
- SW with mem_ready held low, TIMEOUT=4 -> mem_valid high 4 cycles with stable outputs, then low; bus_err one pulse; DONE reached with stall=0.
- rst driven low mid-BUSY, mid-clock -> mem_valid=0 and stall=0 immediately. After release, a new LW completes normally.
